// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: issue-control scoreboard tracking in-flight register writes
//   Stalls decode on RAW hazards (rs1/rs2), per-register WAW counter saturation or
//   total in-flight limit; writeback retires entries, flush drops all tracking.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_dec_valid/o_dec_ready decode handshake (issue = valid & ready)
//   i_rs1/i_rs1_out         source 1 index and read enable
//   i_rs2/i_rs2_out         source 2 index and read enable
//   i_rd/i_rd_we            destination index and write enable
//   i_wb_valid/i_wb_rd      writeback retire event and its destination
//   i_flush                 discard all in-flight tracking
//   o_issue                 registered pulse, issue accepted last cycle
//   o_pending               bit r set while register r has a pending write
//   o_inflight              total pending writes
//   o_err_underflow         sticky, retire seen for a register with nothing pending
module hazard_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int WB_BYPASS    = 1
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_dec_valid,
    output logic                              o_dec_ready,
    input  logic [$clog2(NUM_REGS)-1:0]       i_rs1,
    input  logic                              i_rs1_out,
    input  logic [$clog2(NUM_REGS)-1:0]       i_rs2,
    input  logic                              i_rs2_out,
    input  logic [$clog2(NUM_REGS)-1:0]       i_rd,
    input  logic                              i_rd_we,
    input  logic                              i_wb_valid,
    input  logic [$clog2(NUM_REGS)-1:0]       i_wb_rd,
    input  logic                              i_flush,
    output logic                              o_issue,
    output logic [NUM_REGS-1:0]               o_pending,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] o_inflight,
    output logic                              o_err_underflow
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int IW = $clog2(MAX_INFLIGHT+1);
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt [NUM_REGS];
    logic [IW-1:0]    r_inflight;
    logic             r_issue;
    logic             r_err;

    logic w_ret, w_underflow, w_byp1, w_byp2, w_raw1, w_raw2, w_full, w_waw, w_iss_w;

    // A retire only counts when it hits a register that actually has a pending write;
    // anything else is either ignored (x0) or an underflow error.
    assign w_ret       = i_wb_valid & (i_wb_rd != '0) & (r_cnt[i_wb_rd] != '0);
    assign w_underflow = i_wb_valid & (i_wb_rd != '0) & (r_cnt[i_wb_rd] == '0);
    // Bypass: the last outstanding write to a source retiring this cycle clears its hazard.
    assign w_byp1 = (WB_BYPASS != 0) & i_wb_valid & (i_wb_rd == i_rs1) & (r_cnt[i_rs1] == CNT_W'(1));
    assign w_byp2 = (WB_BYPASS != 0) & i_wb_valid & (i_wb_rd == i_rs2) & (r_cnt[i_rs2] == CNT_W'(1));
    assign w_raw1 = i_rs1_out & (i_rs1 != '0) & (r_cnt[i_rs1] != '0) & !w_byp1;
    assign w_raw2 = i_rs2_out & (i_rs2 != '0) & (r_cnt[i_rs2] != '0) & !w_byp2;
    assign w_full = (r_inflight == IW'(MAX_INFLIGHT)) & !w_ret;
    assign w_waw  = i_rd_we & (i_rd != '0) & (r_cnt[i_rd] == CMAX) & !(w_ret & (i_wb_rd == i_rd));
    assign o_dec_ready = !i_flush & !w_raw1 & !w_raw2 & !w_full & !w_waw;
    assign w_iss_w     = i_dec_valid & o_dec_ready & i_rd_we & (i_rd != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_issue <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_issue <= i_dec_valid & o_dec_ready;
            r_err   <= r_err | (w_underflow & !i_flush);
        end
        for (int r = 0; r < NUM_REGS; r++)
            r_cnt[r] <= (i_rst | i_flush) ? '0 :
                        r_cnt[r] + CNT_W'(w_iss_w && i_rd == AW'(r)) - CNT_W'(w_ret && i_wb_rd == AW'(r));
        r_inflight <= (i_rst | i_flush) ? '0 : r_inflight + IW'(w_iss_w) - IW'(w_ret);
    end

    always_comb begin
        o_pending = '0;
        for (int r = 1; r < NUM_REGS; r++)
            o_pending[r] = r_cnt[r] != '0;
    end

    assign o_issue         = r_issue;
    assign o_inflight      = r_inflight;
    assign o_err_underflow = r_err;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and randomized checks against a counting reference model
module tb_hazard_scoreboard;
    logic       clk = 0;
    logic       rst;
    logic       dec_valid, dec_ready, rs1_out, rs2_out, rd_we, wb_valid, flush;
    logic [4:0] rs1, rs2, rd, wb_rd;
    logic       issue, err;
    logic [31:0] pending;
    logic [2:0]  inflight;

    int n_cmp = 0;
    int n_bad = 0;
    int m_cnt [32];
    int m_inflight;
    int m_err;
    int m_issue;

    hazard_scoreboard dut (
        .i_clk(clk), .i_rst(rst), .i_dec_valid(dec_valid), .o_dec_ready(dec_ready),
        .i_rs1(rs1), .i_rs1_out(rs1_out), .i_rs2(rs2), .i_rs2_out(rs2_out),
        .i_rd(rd), .i_rd_we(rd_we), .i_wb_valid(wb_valid), .i_wb_rd(wb_rd),
        .i_flush(flush), .o_issue(issue), .o_pending(pending), .o_inflight(inflight),
        .o_err_underflow(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_pending();
        logic [31:0] p = '0;
        for (int r = 1; r < 32; r++) p[r] = m_cnt[r] != 0;
        return p;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_inflight = 0;
        m_err = 0;
        m_issue = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".issue"}, 32'(issue), 32'(m_issue));
        check({tag, ".pending"}, pending, exp_pending());
        check({tag, ".inflight"}, 32'(inflight), 32'(m_inflight));
        check({tag, ".err"}, 32'(err), 32'(m_err));
    endtask

    // One clock: drive inputs, check ready against the model, clock, check registered state.
    task automatic step(input string tag, input logic v, input logic [4:0] s1, input logic s1o,
                        input logic [4:0] s2, input logic s2o, input logic [4:0] d, input logic we,
                        input logic wbv, input logic [4:0] wbd, input logic fl);
        bit ret, raw1, raw2, full, waw, rdy;
        dec_valid = v; rs1 = s1; rs1_out = s1o; rs2 = s2; rs2_out = s2o;
        rd = d; rd_we = we; wb_valid = wbv; wb_rd = wbd; flush = fl;
        #1;
        ret  = wbv && wbd != 0 && m_cnt[wbd] > 0;
        raw1 = s1o && s1 != 0 && m_cnt[s1] > 0 && !(wbv && wbd == s1 && m_cnt[s1] == 1);
        raw2 = s2o && s2 != 0 && m_cnt[s2] > 0 && !(wbv && wbd == s2 && m_cnt[s2] == 1);
        full = m_inflight == 4 && !ret;
        waw  = we && d != 0 && m_cnt[d] == 3 && !(ret && wbd == d);
        rdy  = !fl && !raw1 && !raw2 && !full && !waw;
        check({tag, ".ready"}, 32'(dec_ready), 32'(rdy));
        @(posedge clk);
        m_issue = v && rdy;
        if (fl) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
            m_inflight = 0;
        end else begin
            if (wbv && wbd != 0 && m_cnt[wbd] == 0) m_err = 1;
            if (ret) begin m_cnt[wbd]--; m_inflight--; end
            if (m_issue && we && d != 0) begin m_cnt[d]++; m_inflight++; end
        end
        #1;
        check_state(tag);
    endtask

    task automatic wr(input string tag, input logic [4:0] d);
        step(tag, 1, 0, 0, 0, 0, d, 1, 0, 0, 0);
    endtask

    task automatic do_flush(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        int pend_list [$];
        logic [4:0] w;
        logic wv;
        rst = 1; dec_valid = 0; rs1 = 0; rs1_out = 0; rs2 = 0; rs2_out = 0;
        rd = 0; rd_we = 0; wb_valid = 0; wb_rd = 0; flush = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check_state("reset");
        check("reset.ready", 32'(dec_ready), 32'd1);

        wr("raw_issue", 5);
        step("raw_rs1", 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        check("raw_pend5", 32'(pending[5]), 32'd1);
        step("bypass", 1, 0, 0, 5, 1, 0, 0, 1, 5, 0);
        check("bypass_pend5", 32'(pending[5]), 32'd0);

        for (int i = 0; i < 5; i++) wr("x0_write", 0);

        for (int i = 1; i <= 4; i++) wr("fill", 5'(i));
        wr("full_stall", 6);
        step("full_wb", 1, 0, 0, 0, 0, 6, 1, 1, 1, 0);
        check("full_wb_infl", 32'(inflight), 32'd4);
        do_flush("flush1");

        for (int i = 0; i < 3; i++) wr("waw_fill", 7);
        wr("waw_stall", 7);
        step("waw_wb", 1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
        check("waw_infl", 32'(inflight), 32'd3);
        do_flush("flush2");

        for (int k = 0; k < 600; k++) begin
            pend_list.delete();
            for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) pend_list.push_back(r);
            wv = pend_list.size() > 0 && $urandom_range(4) < 2;
            w  = wv ? 5'(pend_list[$urandom_range(pend_list.size() - 1)]) : 5'($urandom_range(9));
            step("rand", 1'($urandom), 5'($urandom_range(9)), 1'($urandom), 5'($urandom_range(9)),
                 1'($urandom), 5'($urandom_range(9)), 1'($urandom_range(3) != 0), wv, w,
                 $urandom_range(40) == 0);
        end
        do_flush("flush3");

        step("underflow", 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        check("underflow_err", 32'(err), 32'd1);
        for (int i = 1; i <= 3; i++) wr("pre_flush", 5'(i));
        do_flush("flush4");
        check("flush4_infl", 32'(inflight), 32'd0);
        check("flush4_pend", pending, 32'd0);

        wr("pre_rst", 11);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        check_state("mid_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
